// File: rtl/sm_seg_display_if.sv
// Load/result handshake and display drive signals of the signed-result display block.
interface sm_seg_display_if #(
  parameter int unsigned MAG_WIDTH = 8
);
  logic                 load;
  logic                 sign_in;
  logic [MAG_WIDTH-1:0] mag_in;
  logic                 busy;
  logic                 done;
  logic [6:0]           seg;
  logic                 dp;
  logic [3:0]           an;

  modport master (
    output load, sign_in, mag_in,
    input  busy, done, seg, dp, an
  );

  modport slave (
    input  load, sign_in, mag_in,
    output busy, done, seg, dp, an
  );
endinterface

// File: rtl/sm_seg_display.sv
// Converts a sign-magnitude result to BCD (double dabble) and scans it onto a
// 4-digit active-low multiplexed seven-segment display.
module sm_seg_display #(
  parameter int unsigned MAG_WIDTH     = 8,
  parameter int unsigned REFRESH_COUNT = 100000
) (
  input  logic              clk_100Mhz,
  input  logic              rst_n,
  sm_seg_display_if.slave   bus
);
  localparam int unsigned SR_W = 12 + MAG_WIDTH;
  localparam int unsigned CW   = $clog2(MAG_WIDTH + 1);
  localparam int unsigned RW   = $clog2(REFRESH_COUNT);
  localparam logic [6:0]  BLANK = 7'h7F;
  localparam logic [6:0]  MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t          state;
  logic [SR_W-1:0] sr, sr_adj;
  logic [CW-1:0]   cnt;
  logic            sign_lat;
  logic            busy_r, done_r;
  logic [3:0]      d_hun, d_ten, d_one;
  logic            d_sign;
  logic [RW-1:0]   ref_cnt;
  logic [1:0]      idx;
  logic [6:0]      seg_r, seg_nxt;
  logic [3:0]      an_r;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = BLANK;
    endcase
  endfunction

  always_comb begin
    sr_adj = sr;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sr[MAG_WIDTH + 4*i +: 4] >= 4'd5)
        sr_adj[MAG_WIDTH + 4*i +: 4] = sr[MAG_WIDTH + 4*i +: 4] + 4'd3;
    end
  end

  // Display registers are written only in UPDATE so a partial conversion is never shown.
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      sign_lat <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      d_hun    <= '0;
      d_ten    <= '0;
      d_one    <= '0;
      d_sign   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            sr       <= SR_W'(bus.mag_in);
            sign_lat <= bus.sign_in;
            cnt      <= CW'(MAG_WIDTH);
            busy_r   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr_adj << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy_r <= 1'b0;
            state  <= UPDATE;
          end
        end
        UPDATE: begin
          d_hun  <= sr[MAG_WIDTH + 8 +: 4];
          d_ten  <= sr[MAG_WIDTH + 4 +: 4];
          d_one  <= sr[MAG_WIDTH +: 4];
          d_sign <= sign_lat & (|sr[SR_W-1:MAG_WIDTH]);
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    seg_nxt = BLANK;
    case (idx)
      2'd0: seg_nxt = enc(d_one);
      2'd1: seg_nxt = (d_hun != 4'd0 || d_ten != 4'd0) ? enc(d_ten) : BLANK;
      2'd2: seg_nxt = (d_hun != 4'd0) ? enc(d_hun) : BLANK;
      2'd3: seg_nxt = d_sign ? MINUS : BLANK;
      default: seg_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      idx     <= '0;
      seg_r   <= BLANK;
      an_r    <= 4'hF;
    end else begin
      if (ref_cnt == RW'(REFRESH_COUNT - 1)) begin
        ref_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + RW'(1);
      end
      an_r  <= ~(4'b0001 << idx);
      seg_r <= seg_nxt;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.seg  = seg_r;
  assign bus.an   = an_r;
  assign bus.dp   = 1'b1;
endmodule

// File: tb/tb_sm_seg_display.sv
// Scoreboard bench for sm_seg_display: expected digit patterns are queued at load
// and compared against the scanned display after each done pulse.
module tb_sm_seg_display;
  localparam int unsigned MW = 8;
  localparam int unsigned RC = 4;

  logic clk_100Mhz = 1'b0;
  logic rst_n      = 1'b0;

  sm_seg_display_if #(.MAG_WIDTH(MW)) bus ();

  sm_seg_display #(.MAG_WIDTH(MW), .REFRESH_COUNT(RC)) dut (
    .clk_100Mhz (clk_100Mhz),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [27:0] exp_q[$];
  logic [6:0]  obs[4];
  int          onehot_bad;

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] model(input logic s, input int v);
    int h, t, o;
    logic [6:0] d3, d2, d1, d0;
    h  = v / 100;
    t  = (v / 10) % 10;
    o  = v % 10;
    d3 = (s && v != 0) ? 7'b0111111 : 7'h7F;
    d2 = (h != 0) ? enc(h) : 7'h7F;
    d1 = (h != 0 || t != 0) ? enc(t) : 7'h7F;
    d0 = enc(o);
    return {d3, d2, d1, d0};
  endfunction

  task automatic drive_load(input logic s, input int m, input bit expect_accept);
    @(negedge clk_100Mhz);
    bus.load    = 1'b1;
    bus.sign_in = s;
    bus.mag_in  = MW'(m);
    if (expect_accept) exp_q.push_back(model(s, m));
    @(posedge clk_100Mhz);
    #1;
    bus.load = 1'b0;
  endtask

  task automatic scan();
    for (int i = 0; i < 4; i++) obs[i] = 7'bx;
    onehot_bad = 0;
    repeat (2) @(posedge clk_100Mhz);
    for (int c = 0; c < 4 * RC + 4; c++) begin
      @(negedge clk_100Mhz);
      if ($countones(~bus.an) != 1) onehot_bad++;
      else begin
        case (bus.an)
          4'b1110: obs[0] = bus.seg;
          4'b1101: obs[1] = bus.seg;
          4'b1011: obs[2] = bus.seg;
          4'b0111: obs[3] = bus.seg;
          default: onehot_bad++;
        endcase
      end
    end
  endtask

  task automatic check_display(input string name);
    logic [27:0] e;
    logic [27:0] o;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, nothing expected", name);
      return;
    end
    e = exp_q.pop_front();
    scan();
    o = {obs[3], obs[2], obs[1], obs[0]};
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $display("FAIL %s digits: got %b %b %b %b expected %b %b %b %b", name,
               o[27:21], o[20:14], o[13:7], o[6:0], e[27:21], e[20:14], e[13:7], e[6:0]);
    end
    n_cmp++;
    if (onehot_bad !== 0) begin
      n_err++;
      $display("FAIL %s anode one-hot: %0d bad cycles expected 0", name, onehot_bad);
    end
  endtask

  task automatic run_conv(input logic s, input int m, input string name);
    int busy_cnt, lat;
    drive_load(s, m, 1'b1);
    busy_cnt = bus.busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_100Mhz);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    n_cmp++;
    if (lat !== 9) begin
      n_err++;
      $display("FAIL %s done latency: got %0d expected 9 (0 = timeout)", name, lat);
    end
    n_cmp++;
    if (busy_cnt !== 8) begin
      n_err++;
      $display("FAIL %s busy cycles: got %0d expected 8", name, busy_cnt);
    end
    @(posedge clk_100Mhz);
    #1;
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL %s done width: done=%b expected 0", name, bus.done);
    end
    check_display(name);
  endtask

  task automatic test_reset();
    logic [3:0] ea;
    logic [6:0] es;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_100Mhz);
    n_cmp++;
    if ({bus.seg, bus.an, bus.dp, bus.busy, bus.done} !== {7'h7F, 4'hF, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset state: seg=%h an=%h dp=%b busy=%b done=%b expected 7f f 1 0 0",
               bus.seg, bus.an, bus.dp, bus.busy, bus.done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_100Mhz);
      ea = ~(4'b0001 << (i / 4));
      es = (i / 4 == 0) ? 7'b1000000 : 7'h7F;
      n_cmp++;
      if (bus.an !== ea || bus.seg !== es) begin
        n_err++;
        $display("FAIL reset scan %0d: an=%b seg=%b expected an=%b seg=%b", i, bus.an, bus.seg, ea, es);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    drive_load(1'b0, 255, 1'b1);
    repeat (2) @(posedge clk_100Mhz);
    @(negedge clk_100Mhz);
    bus.load   = 1'b1;
    bus.mag_in = MW'(1);
    @(posedge clk_100Mhz);
    #1;
    bus.load = 1'b0;
    repeat (5) @(posedge clk_100Mhz);
    #1;
    bus.load = 1'b1;
    @(posedge clk_100Mhz);
    #1;
    bus.load = 1'b0;
    dones = bus.done ? 1 : 0;
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b done timing: done=%b expected 1", bus.done);
    end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk_100Mhz);
      #1;
      if (bus.done) dones++;
    end
    n_cmp++;
    if (dones !== 1) begin
      n_err++;
      $display("FAIL b2b done count: got %0d expected 1", dones);
    end
    check_display("b2b_255");
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL b2b scoreboard leftover: %0d entries expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_conversion();
    int dones;
    drive_load(1'b1, 200, 1'b0);
    repeat (4) @(posedge clk_100Mhz);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.an, bus.seg} !== {1'b0, 1'b0, 4'hF, 7'h7F}) begin
      n_err++;
      $display("FAIL midreset state: busy=%b done=%b an=%h seg=%h expected 0 0 f 7f",
               bus.busy, bus.done, bus.an, bus.seg);
    end
    repeat (2) @(negedge clk_100Mhz);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_100Mhz);
      #1;
      if (bus.done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL midreset done: got %0d pulses expected 0", dones);
    end
    exp_q.push_back(model(1'b0, 0));
    check_display("midreset_blank");
    run_conv(1'b0, 99, "after_reset_99");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load    = 1'b0;
    bus.sign_in = 1'b0;
    bus.mag_in  = '0;
    test_reset();
    run_conv(1'b1, 173, "neg_173");
    run_conv(1'b0, 5,   "pos_5");
    run_conv(1'b0, 40,  "pos_40");
    run_conv(1'b1, 0,   "neg_zero");
    run_conv(1'b0, 255, "max_255");
    test_back_to_back();
    test_reset_mid_conversion();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sm_seg_display.md
Name: sm_seg_display

Overview:
Output side of the sign-magnitude adder user interface. The button debouncer conditions user input; this block presents the signed result on the 4-digit multiplexed seven-segment display.
- Accepts a sign bit and a magnitude on a load strobe.
- Converts the magnitude to BCD with a sequential double-dabble engine.
- Time-multiplexes four digits (sign, hundreds, tens, ones) with active-low segment and anode drives.

Parameters:
MAG_WIDTH, 8, magnitude width in bits; legal range 1..9 (max 511, fits 3 digits).
REFRESH_COUNT, 100000, clock cycles each digit is enabled (1 ms at 100 MHz); minimum 2.

Ports:
clk_100Mhz  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  one-cycle strobe; capture sign_in/mag_in when not busy
sign_in  input  1  1 = negative
mag_in  input  MAG_WIDTH  unsigned magnitude
busy  output  1  conversion in progress; load ignored while high
done  output  1  one-cycle pulse when display registers update
seg  output  7  segments, active low, seg[0]=a .. seg[6]=g
dp  output  1  decimal point, active low, constant 1
an  output  4  digit anodes, active low, an[0]=ones .. an[3]=sign

Behaviour:
- Reset (async assert, sync release):
  - seg=7'h7F, an=4'hF, dp=1, busy=0, done=0.
  - FSM=IDLE, refresh counter=0, digit index=0.
  - Display registers = sign 0, hundreds 0, tens 0, ones 0.
- Reset mid-conversion aborts the conversion; no done pulse is emitted and the display returns to "   0".
- FSM states: IDLE, SHIFT, UPDATE.
  - IDLE: if load=1, capture mag_in into the low bits of a {12-bit BCD, MAG_WIDTH} shift register with BCD=0. Latch sign_in, set shift count=MAG_WIDTH, go to SHIFT, busy=1.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift left by 1 and decrement the count. After MAG_WIDTH shifts, go to UPDATE.
  - UPDATE: write hundreds/tens/ones/sign to the display registers, done=1 for this cycle, busy=0, return to IDLE. A load in this cycle is ignored; the next load is accepted from the following cycle.
- Latency: load sampled at edge 0 → busy high for edges 1..MAG_WIDTH, done high after edge MAG_WIDTH+1.
- load while busy is dropped entirely (not queued); mag_in/sign_in changes while busy have no effect.
- Display formatting:
  - Sign digit shows '-' (7'b0111111) iff latched sign=1 and magnitude!=0. Negative zero displays as "   0". Otherwise the sign digit is blank (7'h7F).
  - Hundreds is blank when 0.
  - Tens is blank when hundreds=0 and tens=0.
  - Ones is always shown.
  - Blank digits keep their anode active with seg=7'h7F.
- Digit encodings, seg[6:0]=gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Scanning:
  - Refresh counter counts 0..REFRESH_COUNT-1 and wraps. At the terminal count, digit index advances 0→1→2→3→0.
  - seg and an are registered every cycle from the current index and display registers: 1-cycle lag after an index or display change.
  - First digit (an=4'b1110) appears on the cycle after reset release.
  - Exactly one an bit is low at any time after the first post-reset edge.
- Display registers change only in UPDATE, so the shown digits never reflect a partial conversion.

Test Plan:
1. Reset with REFRESH_COUNT=4, MAG_WIDTH=8: hold rst_n=0 → seg=7F, an=F, busy=0, done=0. Release → an sequence 1110,1101,1011,0111 each for 4 cycles; ones shows 1000000, others 7F.
2. load, sign_in=1, mag_in=173 → busy=1 for 8 cycles, done pulse on cycle 9. Scan shows an3 '-'(0111111), an2 '1'(1111001), an1 '7'(1111000), an0 '3'(0110000).
3. sign_in=0, mag_in=5 → an3/an2/an1 seg=7F, an0 seg=0010010; sign_in=0, mag_in=40 → an2 blank, an1 '4', an0 '0'.
4. sign_in=1, mag_in=0 → sign digit blank, ones '0'. Also check max value: mag_in=255 → '2','5','5'.
5. load mag_in=255, then load mag_in=1 three cycles later and again in the done cycle → exactly one done pulse, display shows 255.
6. Assert rst_n=0 at SHIFT cycle 4 of a 200 load → no done pulse, display reverts to "   0". A fresh load of 99 after release → tens '9', ones '9', done after 9 cycles.
